// File: rtl/eater_pkg.sv
// Shared constants for the SAP-1 style microcode controller:
// control-bit positions, opcode values and the 16-bit control word type.
package eater_pkg;

  typedef logic [15:0] ctrl_t;

  localparam int B_HLT = 15;
  localparam int B_MI  = 14;
  localparam int B_RI  = 13;
  localparam int B_RO  = 12;
  localparam int B_IO  = 11;
  localparam int B_II  = 10;
  localparam int B_AI  = 9;
  localparam int B_AO  = 8;
  localparam int B_EO  = 7;
  localparam int B_SU  = 6;
  localparam int B_BI  = 5;
  localparam int B_OI  = 4;
  localparam int B_CE  = 3;
  localparam int B_CO  = 2;
  localparam int B_J   = 1;
  localparam int B_FI  = 0;

  localparam ctrl_t C_HLT = ctrl_t'(1) << B_HLT;
  localparam ctrl_t C_MI  = ctrl_t'(1) << B_MI;
  localparam ctrl_t C_RI  = ctrl_t'(1) << B_RI;
  localparam ctrl_t C_RO  = ctrl_t'(1) << B_RO;
  localparam ctrl_t C_IO  = ctrl_t'(1) << B_IO;
  localparam ctrl_t C_II  = ctrl_t'(1) << B_II;
  localparam ctrl_t C_AI  = ctrl_t'(1) << B_AI;
  localparam ctrl_t C_AO  = ctrl_t'(1) << B_AO;
  localparam ctrl_t C_EO  = ctrl_t'(1) << B_EO;
  localparam ctrl_t C_SU  = ctrl_t'(1) << B_SU;
  localparam ctrl_t C_BI  = ctrl_t'(1) << B_BI;
  localparam ctrl_t C_OI  = ctrl_t'(1) << B_OI;
  localparam ctrl_t C_CE  = ctrl_t'(1) << B_CE;
  localparam ctrl_t C_CO  = ctrl_t'(1) << B_CO;
  localparam ctrl_t C_J   = ctrl_t'(1) << B_J;
  localparam ctrl_t C_FI  = ctrl_t'(1) << B_FI;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam ctrl_t FETCH0 = C_CO | C_MI;
  localparam ctrl_t FETCH1 = C_RO | C_II | C_CE;

endpackage

// File: rtl/eater_udecode.sv
// Combinational microcode ROM: (opcode, step, flags) -> control word and
// the last step this opcode actually uses (clamped to STEPS-1).
module eater_udecode
  import eater_pkg::*;
#(
  parameter int STEPS = 5,
  parameter int OP_W  = 4
) (
  input  logic [OP_W-1:0] opcode,
  input  logic [2:0]      step,
  input  logic            cf,
  input  logic            zf,
  output ctrl_t           ctrl,
  output logic [2:0]      last_step
);

  logic [3:0] op;
  logic [2:0] k;
  logic [2:0] n_exec;
  logic [3:0] raw_last;
  ctrl_t      exec;

  // Anything outside the 4-bit opcode space is a NOP.
  assign op = (32'(opcode) > 32'd15) ? OP_NOP : 4'(opcode);
  assign k  = step - 3'd2;

  always_comb begin
    exec   = '0;
    n_exec = 3'd0;
    unique case (op)
      OP_LDA: begin
        n_exec = 3'd2;
        exec   = (k == 3'd0) ? (C_IO | C_MI) : (C_RO | C_AI);
      end
      OP_ADD, OP_SUB: begin
        n_exec = 3'd3;
        case (k)
          3'd0:    exec = C_IO | C_MI;
          3'd1:    exec = C_RO | C_BI;
          default: exec = C_EO | C_AI | C_FI | ((op == OP_SUB) ? C_SU : ctrl_t'(0));
        endcase
      end
      OP_STA: begin
        n_exec = 3'd2;
        exec   = (k == 3'd0) ? (C_IO | C_MI) : (C_AO | C_RI);
      end
      OP_LDI: begin
        n_exec = 3'd1;
        exec   = C_IO | C_AI;
      end
      OP_JMP: begin
        n_exec = 3'd1;
        exec   = C_IO | C_J;
      end
      OP_JC: begin
        n_exec = cf ? 3'd1 : 3'd0;
        exec   = C_IO | C_J;
      end
      OP_JZ: begin
        n_exec = zf ? 3'd1 : 3'd0;
        exec   = C_IO | C_J;
      end
      OP_OUT: begin
        n_exec = 3'd1;
        exec   = C_AO | C_OI;
      end
      OP_HLT: begin
        n_exec = 3'd1;
        exec   = C_HLT;
      end
      default: begin
        n_exec = 3'd0;
        exec   = '0;
      end
    endcase
  end

  always_comb begin
    ctrl = '0;
    if (step == 3'd0)      ctrl = FETCH0;
    else if (step == 3'd1) ctrl = FETCH1;
    else if (k < n_exec)   ctrl = exec;
  end

  assign raw_last  = {1'b0, n_exec} + 4'd1;
  assign last_step = (raw_last > 4'(STEPS - 1)) ? 3'(STEPS - 1) : raw_last[2:0];

endmodule

// File: rtl/eater_ctrl.sv
// Microstep sequencer: step counter with early restart, single-step gating
// and a sticky halt that freezes the step and forces the HLT-only word.
module eater_ctrl
  import eater_pkg::*;
#(
  parameter int STEPS       = 5,
  parameter int OP_W        = 4,
  parameter int EARLY_END   = 1,
  parameter int SINGLE_STEP = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            cf,
  input  logic            zf,
  input  logic            step_req,
  output logic [15:0]     ctrl_state,
  output logic [2:0]      step,
  output logic            halted
);

  localparam logic [2:0] STEP_MAX = 3'(STEPS - 1);

  logic [2:0] step_q, step_d, last;
  logic       halted_q, halted_d, en;
  ctrl_t      dec;

  eater_udecode #(.STEPS(STEPS), .OP_W(OP_W)) u_dec (
    .opcode    (opcode),
    .step      (step_q),
    .cf        (cf),
    .zf        (zf),
    .ctrl      (dec),
    .last_step (last)
  );

  assign en = (SINGLE_STEP != 0) ? step_req : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q   <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // A step carrying HLT latches the halt and holds the counter where it is.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q && en) begin
      if (dec[B_HLT])
        halted_d = 1'b1;
      else if (((EARLY_END != 0) && (step_q == last)) || (step_q == STEP_MAX))
        step_d = 3'd0;
      else
        step_d = step_q + 3'd1;
    end
  end

  always_comb begin
    ctrl_state = halted_q ? C_HLT : dec;
  end

  assign step   = step_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_eater_ctrl.sv
// Randomized scoreboard bench for eater_ctrl across four parameter sets,
// plus directed instruction sequences with known control words.
module tb_eater_ctrl;

  localparam int N = 4;
  localparam int ST [N] = '{5, 5, 5, 3};
  localparam int EE [N] = '{1, 0, 1, 1};
  localparam int SS [N] = '{0, 0, 1, 0};

  localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
  localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
  localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
  localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, JP = 16'h0002, FI = 16'h0001;

  logic clk = 1'b0;
  logic rst, cf, zf, step_req;
  logic [4:0] opcode;
  logic [N-1:0][15:0] ctrl_o;
  logic [N-1:0][2:0]  step_o;
  logic [N-1:0]       halted_o;

  typedef struct packed {
    logic [N-1:0][15:0] c;
    logic [N-1:0][2:0]  s;
    logic [N-1:0]       h;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   ms [N];
  bit   mh [N];
  int   tests = 0, fails = 0;

  always #5 clk = ~clk;

  eater_ctrl #(.STEPS(5), .OP_W(4), .EARLY_END(1), .SINGLE_STEP(0)) dut0 (
    .clk(clk), .rst(rst), .opcode(opcode[3:0]), .cf(cf), .zf(zf), .step_req(step_req),
    .ctrl_state(ctrl_o[0]), .step(step_o[0]), .halted(halted_o[0]));
  eater_ctrl #(.STEPS(5), .OP_W(4), .EARLY_END(0), .SINGLE_STEP(0)) dut1 (
    .clk(clk), .rst(rst), .opcode(opcode[3:0]), .cf(cf), .zf(zf), .step_req(step_req),
    .ctrl_state(ctrl_o[1]), .step(step_o[1]), .halted(halted_o[1]));
  eater_ctrl #(.STEPS(5), .OP_W(4), .EARLY_END(1), .SINGLE_STEP(1)) dut2 (
    .clk(clk), .rst(rst), .opcode(opcode[3:0]), .cf(cf), .zf(zf), .step_req(step_req),
    .ctrl_state(ctrl_o[2]), .step(step_o[2]), .halted(halted_o[2]));
  eater_ctrl #(.STEPS(3), .OP_W(5), .EARLY_END(1), .SINGLE_STEP(0)) dut3 (
    .clk(clk), .rst(rst), .opcode(opcode), .cf(cf), .zf(zf), .step_req(step_req),
    .ctrl_state(ctrl_o[3]), .step(step_o[3]), .halted(halted_o[3]));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Execute-phase words of one instruction, in order, after the two fetch steps.
  function automatic void program_of(input int op, input bit c, input bit z,
                                     output logic [2:0][15:0] w, output int n);
    w = '0; n = 0;
    case (op)
      1:  begin w[0] = IO|MI; w[1] = RO|AI; n = 2; end
      2:  begin w[0] = IO|MI; w[1] = RO|BI; w[2] = EO|AI|FI; n = 3; end
      3:  begin w[0] = IO|MI; w[1] = RO|BI; w[2] = EO|AI|SU|FI; n = 3; end
      4:  begin w[0] = IO|MI; w[1] = AO|RI; n = 2; end
      5:  begin w[0] = IO|AI; n = 1; end
      6:  begin w[0] = IO|JP; n = 1; end
      7:  if (c) begin w[0] = IO|JP; n = 1; end
      8:  if (z) begin w[0] = IO|JP; n = 1; end
      14: begin w[0] = AO|OI; n = 1; end
      15: begin w[0] = HLT; n = 1; end
      default: n = 0;
    endcase
  endfunction

  function automatic int opv(input int i);
    return (i == 3) ? int'(opcode) : int'(opcode[3:0]);
  endfunction

  function automatic logic [15:0] exp_ctrl(input int i);
    logic [2:0][15:0] w;
    int n;
    if (mh[i]) return HLT;
    if (ms[i] == 0) return CO|MI;
    if (ms[i] == 1) return RO|II|CE;
    program_of(opv(i), cf, zf, w, n);
    return (ms[i] - 2 < n) ? w[ms[i] - 2] : 16'h0;
  endfunction

  task automatic model_update();
    logic [2:0][15:0] w;
    int n, last;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        ms[i] = 0; mh[i] = 0;
      end else if (!mh[i] && (SS[i] == 0 || step_req)) begin
        if (exp_ctrl(i) == HLT) mh[i] = 1;
        else begin
          program_of(opv(i), cf, zf, w, n);
          last = (1 + n < ST[i] - 1) ? 1 + n : ST[i] - 1;
          if ((EE[i] != 0 && ms[i] == last) || ms[i] == ST[i] - 1) ms[i] = 0;
          else ms[i] = ms[i] + 1;
        end
      end
    end
  endtask

  task automatic begin_cycle();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.c[i] = exp_ctrl(i);
      e.s[i] = 3'(ms[i]);
      e.h[i] = mh[i];
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic end_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    begin_cycle(); end_cycle();
  endtask

  task automatic tchk(input string nm, input logic [15:0] exp);
    begin_cycle(); chk(nm, ctrl_o[0], exp); end_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  // Monitor: compare every DUT against the queued model prediction.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      for (int i = 0; i < N; i++) begin
        chk($sformatf("dut%0d ctrl", i), ctrl_o[i], me.c[i]);
        chk($sformatf("dut%0d step", i), 16'(step_o[i]), 16'(me.s[i]));
        chk($sformatf("dut%0d halted", i), 16'(halted_o[i]), 16'(me.h[i]));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] prev;
    bit req_prev;
    rst = 1'b1; cf = 1'b0; zf = 1'b0; step_req = 1'b0; opcode = 5'd0;
    for (int i = 0; i < N; i++) begin ms[i] = 0; mh[i] = 0; end
    @(posedge clk); #1;
    do_reset();

    opcode = 5'd1;
    tchk("lda s0", 16'h4004); tchk("lda s1", 16'h1408);
    tchk("lda s2", 16'h4800); tchk("lda s3", 16'h1200);
    begin_cycle(); chk("lda wrap", 16'(step_o[0]), 16'd0); end_cycle();

    do_reset(); opcode = 5'd2;
    tchk("add s0", 16'h4004); tchk("add s1", 16'h1408); tchk("add s2", 16'h4800);
    tchk("add s3", 16'h1020); tchk("add s4", 16'h0281);
    begin_cycle(); chk("add wrap", 16'(step_o[0]), 16'd0); end_cycle();

    do_reset(); opcode = 5'd7; cf = 1'b0;
    tchk("jc0 s0", 16'h4004); tchk("jc0 s1", 16'h1408);
    begin_cycle(); chk("jc0 restart", 16'(step_o[0]), 16'd0); end_cycle();
    do_reset(); cf = 1'b1;
    tchk("jc1 s0", 16'h4004); tchk("jc1 s1", 16'h1408); tchk("jc1 s2", 16'h0802);
    begin_cycle(); chk("jc1 restart", 16'(step_o[0]), 16'd0); end_cycle();
    cf = 1'b0;

    do_reset(); opcode = 5'd3;
    tick(); tick(); tick();
    begin_cycle(); chk("sub s3", ctrl_o[0], 16'h1020); rst = 1'b1; end_cycle();
    rst = 1'b0;
    begin_cycle();
    chk("sub rst step", 16'(step_o[0]), 16'd0);
    chk("sub rst ctrl", ctrl_o[0], 16'h4004);
    chk("sub rst halted", 16'(halted_o[0]), 16'd0);
    end_cycle();

    do_reset(); opcode = 5'd15;
    tick(); tick();
    begin_cycle(); chk("hlt s2", ctrl_o[0], 16'h8000); end_cycle();
    for (int c = 0; c < 10; c++) begin
      begin_cycle();
      chk("hlt halted", 16'(halted_o[0]), 16'd1);
      chk("hlt ctrl", ctrl_o[0], 16'h8000);
      chk("hlt step", 16'(step_o[0]), 16'd2);
      end_cycle();
    end

    do_reset(); opcode = 5'd1;
    prev = 3'd0; req_prev = 1'b0;
    for (int c = 0; c < 13; c++) begin
      step_req = (c % 3 == 0);
      begin_cycle();
      if (c > 0) chk("single step", 16'(step_o[2] != prev), 16'(req_prev));
      prev = step_o[2]; req_prev = step_req;
      end_cycle();
    end
    step_req = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) opcode = 5'($urandom_range(0, 31));
      cf = 1'($urandom); zf = 1'($urandom); step_req = 1'($urandom);
      rst = ($urandom_range(0, 59) == 0) ||
            (mh[0] && mh[1] && mh[3] && $urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b0;

    for (int c = 0; c < 10 && q.size() > 0; c++) @(negedge clk);
    chk("scoreboard drained", 16'(q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eater_ctrl.md
EATER_CTRL -- requirements
Module: eater_ctrl

Interface
REQ-001 SHALL take parameter STEPS, default 5, meaning the microstep count per instruction (legal 3..8).
REQ-002 SHALL take parameter OP_W, default 4, meaning the opcode width; opcode values above 15 decode as NOP.
REQ-003 SHALL take parameter EARLY_END, default 1, meaning 1 = restart fetch after an opcode's last used step, 0 = always run all STEPS.
REQ-004 SHALL take parameter SINGLE_STEP, default 0, meaning 1 = step counter advances only on step_req.
REQ-005 SHALL use one clock, with reset synchronous and active-high.
REQ-006 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port opcode, input, OP_W bits: instruction register upper field.
REQ-009 SHALL have port cf, input, 1 bit: latched carry flag.
REQ-010 SHALL have port zf, input, 1 bit: latched zero flag.
REQ-011 SHALL have port step_req, input, 1 bit: manual advance pulse, ignored when SINGLE_STEP=0.
REQ-012 SHALL have port ctrl_state, output, 16 bits: control word, bits 15..0 = HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI.
REQ-013 SHALL have port step, output, 3 bits: current microstep.
REQ-014 SHALL have port halted, output, 1 bit: high once HLT has executed.

Function
REQ-015 SHALL hold step in a register; ctrl_state SHALL be combinational from step, opcode, cf, zf and halted, with zero latency.
REQ-016 SHALL drive CO|MI at step 0 and RO|II|CE at step 1 for every opcode.
REQ-017 SHALL decode steps 2+ as follows: NOP(0) none; LDA(1) IO|MI, RO|AI; ADD(2) IO|MI, RO|BI, EO|AI|FI; SUB(3) IO|MI, RO|BI, EO|AI|SU|FI; STA(4) IO|MI, AI... corrected: AO|RI; LDI(5) IO|AI; JMP(6) IO|J; JC(7) IO|J if cf else none; JZ(8) IO|J if zf else none; OUT(14) AO|OI; HLT(15) HLT; opcodes 9..13 decode as NOP.
REQ-018 SHALL define each opcode's last used step as 1 + its number of execute steps (NOP, and JC/JZ not taken, last = 1); opcodes needing more steps than STEPS-2 SHALL be truncated at step STEPS-1.
REQ-019 SHALL advance step each enabled cycle; the enable is 1 when SINGLE_STEP=0 and step_req when SINGLE_STEP=1.
REQ-020 SHALL, when EARLY_END=1, load 0 on an enabled cycle at the last used step; otherwise wrap STEPS-1 -> 0.
REQ-021 SHALL set halted at the clock edge ending a step whose ctrl_state has HLT asserted; once set, step SHALL freeze and ctrl_state SHALL equal HLT only, until rst.
REQ-022 SHALL let rst win over step_req and halt in the same cycle.
REQ-023 SHALL evaluate conditional jumps on cf/zf as sampled during the jump step itself.

Reset
REQ-024 SHALL, on rst high at a rising edge, set step=0 and halted=0; ctrl_state SHALL then read CO|MI, including when rst is asserted mid-instruction.

Structure
REQ-025 SHALL place the control bit indices, opcode constants and the 16-bit control word type in a shared package eater_pkg.
REQ-026 SHALL use one sub-module, eater_udecode: combinational (opcode, step, cf, zf) -> control word plus last_step.

Verification
REQ-027 SHALL cover: rst, then opcode=1 (LDA) with EARLY_END=1 -> ctrl sequence 0x4004, 0x1408, 0x4800, 0x1200, then step=0.
REQ-028 SHALL cover: opcode=2 (ADD) with STEPS=5 -> step-4 word 0x0281 (EO|AI|FI), then wrap to 0.
REQ-029 SHALL cover: opcode=7 (JC) with cf=0 -> step returns to 0 after step 1 when EARLY_END=1; with cf=1 -> step 2 word 0x0802.
REQ-030 SHALL cover: opcode=15 (HLT) -> halted=1 after step 2; ctrl_state=0x8000 for 10 further cycles; step frozen at 2.
REQ-031 SHALL cover: SINGLE_STEP=1, step_req pulsed every 3rd cycle -> step changes only on pulse cycles.
REQ-032 SHALL cover: rst asserted at step 3 of SUB -> next cycle step=0, ctrl_state=0x4004, halted=0.
